// File: rtl/rcc_reg_bus_arb.sv
// rcc_reg_bus_arb: two-master round-robin arbiter and sequencer for the RCC
// register-file port. One transaction is in flight at a time. The slave gets
// a registered one-cycle request, the response is bounded by a timeout, and
// the result is returned only to the master that was granted.
module rcc_reg_bus_arb #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int WW      = 4,
    parameter int TIMEOUT = 16
) (
    input  logic          hclk,
    input  logic          rst,
    // master 0: AHB-to-register bridge
    input  logic          m0_req,
    input  logic [WW-1:0] m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_done,
    output logic [DW-1:0] m0_rdata,
    output logic [1:0]    m0_rsp,
    // master 1: internal hardware requester
    input  logic          m1_req,
    input  logic [WW-1:0] m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_done,
    output logic [DW-1:0] m1_rdata,
    output logic [1:0]    m1_rsp,
    // register-file side
    output logic          s_req,
    output logic [WW-1:0] s_we,
    output logic [AW-1:0] s_addr,
    output logic [DW-1:0] s_wdata,
    input  logic          s_rvalid,
    input  logic [DW-1:0] s_rdata,
    input  logic [1:0]    s_rsp,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] RSP_OK      = 2'b00;
    localparam logic [1:0] RSP_SLVERR  = 2'b01;
    localparam logic [1:0] RSP_TIMEOUT = 2'b10;
    localparam logic [7:0] TMO_LOAD    = 8'(TIMEOUT);

    state_t        state;
    logic          last_grant;   // master served by the previous transaction
    logic          grant;        // master owning the current transaction
    logic [7:0]    timer;

    // arbitration and response-selection terms
    logic          win;          // master that would be granted this cycle
    logic          rsp_fire;     // transaction ends this cycle
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_code;

    // Pick the winner and the completion data from current inputs; all of
    // it is consumed only by the registers below, so no input reaches an
    // output combinationally.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        win       = 1'b0;
        rsp_fire  = 1'b0;
        rsp_rdata = '0;
        rsp_code  = RSP_OK;

        // m1 wins when alone, or when both ask and m0 was served last
        win = m1_req & (~m0_req | (last_grant == 1'b0));

        if (state == WAIT) begin
            if (s_rvalid) begin
                // a response in the expiry cycle still counts as a response
                rsp_fire  = 1'b1;
                rsp_rdata = s_rdata;
                rsp_code  = (s_rsp != RSP_OK) ? RSP_SLVERR : RSP_OK;
            end else if (timer == 8'd1) begin
                rsp_fire  = 1'b1;
                rsp_rdata = '0;
                rsp_code  = RSP_TIMEOUT;
            end
        end
    end

    // Transaction sequencer: IDLE -> ISSUE -> WAIT -> DONE with registered outputs.
    always_ff @(posedge hclk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the values from before this clock edge.
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant      <= 1'b0;
            timer      <= '0;
            s_req      <= 1'b0;
            s_we       <= '0;
            s_addr     <= '0;
            s_wdata    <= '0;
            m0_done    <= 1'b0;
            m0_rdata   <= '0;
            m0_rsp     <= RSP_OK;
            m1_done    <= 1'b0;
            m1_rdata   <= '0;
            m1_rsp     <= RSP_OK;
        end else begin
            // pulses default low and are raised only for their one cycle
            s_req   <= 1'b0;
            m0_done <= 1'b0;
            m1_done <= 1'b0;

            case (state)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        grant   <= win;
                        s_we    <= win ? m1_we    : m0_we;
                        s_addr  <= win ? m1_addr  : m0_addr;
                        s_wdata <= win ? m1_wdata : m0_wdata;
                        s_req   <= 1'b1;
                        state   <= ISSUE;
                    end
                end

                ISSUE: begin
                    timer <= TMO_LOAD;
                    state <= WAIT;
                end

                WAIT: begin
                    if (rsp_fire) begin
                        timer <= '0;
                        state <= DONE;
                        if (grant) begin
                            m1_done  <= 1'b1;
                            m1_rdata <= rsp_rdata;
                            m1_rsp   <= rsp_code;
                        end else begin
                            m0_done  <= 1'b1;
                            m0_rdata <= rsp_rdata;
                            m0_rsp   <= rsp_code;
                        end
                    end else begin
                        timer <= timer - 8'd1;
                    end
                end

                DONE: begin
                    last_grant <= grant;
                    state      <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_rcc_reg_bus_arb.sv
// tb_rcc_reg_bus_arb: directed, table-driven bench for rcc_reg_bus_arb.
// Solo transactions come from a vector table; contention, stray responses
// and reset in the middle of a transaction are hand-written sequences.
module tb_rcc_reg_bus_arb;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int WW      = 4;
    localparam int TIMEOUT = 16;

    logic          hclk = 1'b0;
    logic          rst;
    logic          m0_req, m1_req;
    logic [WW-1:0] m0_we, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_done, m1_done;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic [1:0]    m0_rsp, m1_rsp;
    logic          s_req;
    logic [WW-1:0] s_we;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata;
    logic          s_rvalid;
    logic [DW-1:0] s_rdata;
    logic [1:0]    s_rsp;
    logic          busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    rcc_reg_bus_arb #(.AW(AW), .DW(DW), .WW(WW), .TIMEOUT(TIMEOUT)) dut (
        .hclk(hclk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_done(m0_done), .m0_rdata(m0_rdata), .m0_rsp(m0_rsp),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_done(m1_done), .m1_rdata(m1_rdata), .m1_rsp(m1_rsp),
        .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rsp(s_rsp),
        .busy(busy)
    );

    always #5 hclk = ~hclk;

    // one solo transaction: master, request fields, slave behaviour, expectations
    typedef struct {
        int          master;
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          k;            // WAIT cycle of s_rvalid, 0 = never
        logic [31:0] srdata;
        logic [1:0]  srsp;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_rsp;
        int          exp_done_at;  // cycles from s_req to done
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // advance to just after the next rising edge
    task automatic tick();
        @(posedge hclk);
        #1;
        cyc++;
    endtask

    task automatic idle_inputs();
        m0_req = 1'b0; m0_we = '0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_we = '0; m1_addr = '0; m1_wdata = '0;
        s_rvalid = 1'b0; s_rdata = '0; s_rsp = '0;
    endtask

    // Starts in IDLE just after an edge; ends in IDLE after the done pulse.
    task automatic run_vec(input vec_t v, input int idx);
        int  c;
        bit  got;
        if (v.master == 0) begin
            m0_req = 1'b1; m0_we = v.we; m0_addr = v.addr; m0_wdata = v.wdata;
        end else begin
            m1_req = 1'b1; m1_we = v.we; m1_addr = v.addr; m1_wdata = v.wdata;
        end
        tick();
        check($sformatf("v%0d s_req", idx), 32'(s_req), 32'd1);
        check($sformatf("v%0d s_addr", idx), s_addr, v.addr);
        check($sformatf("v%0d s_we", idx), 32'(s_we), 32'(v.we));
        check($sformatf("v%0d s_wdata", idx), s_wdata, v.wdata);

        got = 1'b0;
        c   = 0;
        while (!got && c < TIMEOUT + 6) begin
            tick();
            c++;
            if (m0_done || m1_done) begin
                got = 1'b1;
            end else begin
                check($sformatf("v%0d s_req low in WAIT", idx), 32'(s_req), 32'd0);
                s_rvalid = (c == v.k);
                s_rdata  = (c == v.k) ? v.srdata : 32'hA5A5_0000;
                s_rsp    = (c == v.k) ? v.srsp : 2'b00;
            end
        end
        s_rvalid = 1'b0;
        m0_req = 1'b0;
        m1_req = 1'b0;

        if (!got) begin
            check($sformatf("v%0d done never arrived", idx), 32'd0, 32'd1);
        end else begin
            check($sformatf("v%0d done latency", idx), 32'(c), 32'(v.exp_done_at));
            check($sformatf("v%0d m0_done", idx), 32'(m0_done), 32'(v.master == 0));
            check($sformatf("v%0d m1_done", idx), 32'(m1_done), 32'(v.master == 1));
            check($sformatf("v%0d rdata", idx), (v.master == 0) ? m0_rdata : m1_rdata, v.exp_rdata);
            check($sformatf("v%0d rsp", idx), 32'((v.master == 0) ? m0_rsp : m1_rsp), 32'(v.exp_rsp));
        end

        tick();
        check($sformatf("v%0d busy after done", idx), 32'(busy), 32'd0);
        check($sformatf("v%0d done one cycle", idx), 32'(m0_done | m1_done), 32'd0);
        check($sformatf("v%0d rdata held", idx), (v.master == 0) ? m0_rdata : m1_rdata, v.exp_rdata);
    endtask

    initial begin
        int n;
        int last_sreq;

        vecs[0] = '{0, 4'h0, 32'h10, 32'h0,        2,  32'hDEADBEEF, 2'b00, 32'hDEADBEEF, 2'b00, 3};
        vecs[1] = '{1, 4'hF, 32'h80, 32'h5A5A,     0,  32'h0,        2'b00, 32'h0,        2'b10, 17};
        vecs[2] = '{0, 4'h3, 32'h24, 32'h12345678, 16, 32'hCAFEF00D, 2'b01, 32'hCAFEF00D, 2'b01, 17};
        vecs[3] = '{1, 4'h0, 32'h44, 32'h0,        1,  32'h0BADC0DE, 2'b00, 32'h0BADC0DE, 2'b00, 2};
        vecs[4] = '{1, 4'h0, 32'h4C, 32'h0,        15, 32'h11112222, 2'b11, 32'h11112222, 2'b01, 16};
        vecs[5] = '{0, 4'h0, 32'h58, 32'h0,        3,  32'h55556666, 2'b10, 32'h55556666, 2'b01, 4};

        // ---- reset with both masters already requesting ----
        idle_inputs();
        rst = 1'b1;
        m0_req = 1'b1; m0_addr = 32'hA0;
        m1_req = 1'b1; m1_addr = 32'hB0;
        tick();
        tick();
        check("reset busy", 32'(busy), 32'd0);
        check("reset s_req", 32'(s_req), 32'd0);
        check("reset dones", 32'({m0_done, m1_done}), 32'd0);
        check("reset s_addr", s_addr, 32'd0);
        check("reset m0_rdata", m0_rdata, 32'd0);
        check("reset m1_rsp", 32'(m1_rsp), 32'd0);
        rst = 1'b0;

        // ---- contention: grants alternate 0,1,0,1 starting with m0 ----
        last_sreq = 0;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            do begin
                tick();
                n++;
            end while (!s_req && n < 8);
            check($sformatf("cont%0d s_req seen", i), 32'(s_req), 32'd1);
            check($sformatf("cont%0d winner addr", i), s_addr, (i % 2 == 0) ? 32'hA0 : 32'hB0);
            if (i > 0) check($sformatf("cont%0d grant spacing", i), 32'(cyc - last_sreq), 32'd4);
            last_sreq = cyc;
            tick();                       // first WAIT cycle: respond with k=1
            s_rvalid = 1'b1;
            s_rdata  = 32'h1000 + 32'(i);
            s_rsp    = 2'b00;
            tick();                       // DONE cycle
            s_rvalid = 1'b0;
            if (i == 3) begin
                m0_req = 1'b0;
                m1_req = 1'b0;
            end
            check($sformatf("cont%0d m0_done", i), 32'(m0_done), 32'(i % 2 == 0));
            check($sformatf("cont%0d m1_done", i), 32'(m1_done), 32'(i % 2 == 1));
            check($sformatf("cont%0d rdata", i), (i % 2 == 0) ? m0_rdata : m1_rdata, 32'h1000 + 32'(i));
        end
        idle_inputs();
        tick();
        check("cont idle after", 32'(busy), 32'd0);

        // ---- solo transactions from the table ----
        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], i);
        end

        // ---- stray s_rvalid in IDLE is ignored ----
        s_rvalid = 1'b1; s_rdata = 32'hFFFFFFFF; s_rsp = 2'b01;
        tick();
        s_rvalid = 1'b0;
        check("stray busy", 32'(busy), 32'd0);
        check("stray dones", 32'({m0_done, m1_done}), 32'd0);
        tick();
        check("stray dones later", 32'({m0_done, m1_done}), 32'd0);
        check("stray m0_rdata kept", m0_rdata, 32'h55556666);
        check("stray m0_rsp kept", 32'(m0_rsp), 32'd1);

        // ---- reset in the middle of WAIT discards the transaction ----
        m0_req = 1'b1; m0_addr = 32'h30;
        tick();
        check("rstw s_req", 32'(s_req), 32'd1);
        tick();                           // WAIT 1
        tick();                           // WAIT 2
        check("rstw busy before", 32'(busy), 32'd1);
        rst = 1'b1;
        m0_req = 1'b0;
        tick();
        rst = 1'b0;
        check("rstw busy", 32'(busy), 32'd0);
        check("rstw s_req", 32'(s_req), 32'd0);
        check("rstw dones", 32'({m0_done, m1_done}), 32'd0);
        check("rstw s_addr cleared", s_addr, 32'd0);
        check("rstw m0_rdata cleared", m0_rdata, 32'd0);
        s_rvalid = 1'b1; s_rdata = 32'h77777777;   // late response
        tick();
        s_rvalid = 1'b0;
        check("rstw late rvalid busy", 32'(busy), 32'd0);
        check("rstw late rvalid dones", 32'({m0_done, m1_done}), 32'd0);
        tick();
        check("rstw late rvalid dones later", 32'({m0_done, m1_done}), 32'd0);

        // last grant before reset was m0; reset must make m0 win the tie again
        m0_req = 1'b1; m0_addr = 32'h100;
        m1_req = 1'b1; m1_addr = 32'h200;
        tick();
        check("post-reset first grant", s_addr, 32'h100);
        tick();
        s_rvalid = 1'b1; s_rdata = 32'h2468ACE0; s_rsp = 2'b00;
        tick();
        s_rvalid = 1'b0;
        m0_req = 1'b0;
        check("post-reset m0_done", 32'(m0_done), 32'd1);
        check("post-reset m0_rdata", m0_rdata, 32'h2468ACE0);
        tick();                           // IDLE samples m1 alone
        tick();
        check("post-reset second grant", s_addr, 32'h200);
        m1_req = 1'b0;
        tick();
        s_rvalid = 1'b1; s_rdata = 32'h13579BDF; s_rsp = 2'b00;
        tick();
        s_rvalid = 1'b0;
        check("post-reset m1_done", 32'(m1_done), 32'd1);
        check("post-reset m1_rdata", m1_rdata, 32'h13579BDF);
        tick();
        check("final idle", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // absolute backstop so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule
